pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register for inter-stage boundaries such as IF/ID, ID/EX, EX/MEM and MEM/WB. It carries an opaque payload bus and replaces the plain stall/flush latch with a valid/ready handshake. An optional second-entry skid buffer lets back-pressure register-break the ready path without losing data. Synchronous flush inserts a bubble, and the payload is zeroed whenever the stage is empty, so downstream control bits read as a NOP.

Parameters:
DATA_W, 160, payload width in bits (all stage fields concatenated by the instantiating level).
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous; discards all held entries this cycle
in_valid  input  1  upstream has a payload
in_ready  output  1  stage can accept this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head this cycle
out_data  output  DATA_W  head payload; all-zero when out_valid=0
occupancy  output  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset (async, rst=1): main and skid entries cleared. out_valid=0, out_data=0, occupancy=0, in_ready=1. The reset takes effect immediately, not at the next clock edge, and overrides any transfer in progress.
- Handshakes:
  - push = in_valid & in_ready; pop = out_valid & out_ready; both are sampled at the rising edge.
  - in_data is ignored when in_valid=0 or in_ready=0.
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Latency: one cycle in to out when empty. A payload pushed at edge N is visible on out_data after edge N.
- SKID=1, states EMPTY(occ 0), ONE(occ 1), FULL(occ 2); main = head, skid = second entry:
  - EMPTY: push -> ONE (main <= in_data).
  - ONE: push & !pop -> FULL (skid <= in_data); push & pop -> ONE (main <= in_data); !push & pop -> EMPTY (main <= 0); otherwise hold.
  - FULL: pop -> ONE (main <= skid, skid <= 0). push is impossible because in_ready=0.
  - in_ready = (state != FULL). It is a registered signal with no combinational path from out_ready.
- SKID=0: single entry, EMPTY/ONE only.
  - in_ready = !out_valid | out_ready (combinational).
  - push & pop: main <= in_data, stays ONE.
  - pop without push: main <= 0, goes EMPTY.
- Flush:
  - Next state is EMPTY and all entries are zeroed. This holds regardless of push/pop in the same cycle; a coincident push is dropped and a coincident pop is still counted as consumed by downstream.
  - After the flush edge, in_ready=1 in both modes.
  - rst has priority over flush.
- Bubble rule: any entry not holding valid data is all-zero, including the skid entry. out_data is 0 whenever out_valid=0.
- occupancy equals the state encoding exactly. out_valid = (occupancy != 0).
- Data ordering is strictly FIFO. No payload is duplicated or dropped, except on flush or rst.

Test Plan:
1. SKID=1: rst pulse mid-cycle while FULL -> out_valid, occupancy and out_data go to 0 before the next edge; in_ready=1.
2. SKID=1, out_ready=1: stream in_data 0x1,0x2,0x3 on consecutive cycles -> out_data shows 0x1,0x2,0x3 one cycle later each; occupancy stays 1; in_ready stays 1.
3. SKID=1: push 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA, then 0xB, then out_valid=0 with out_data=0.
4. SKID=1, FULL: assert flush with in_valid=1, in_data=0xC -> next cycle occupancy=0, out_data=0, in_ready=1; 0xC is never emitted.
5. SKID=0: out_ready=0 while ONE -> in_ready=0 in the same cycle. Toggle out_ready=1 with in_valid=1, in_data=0x5 -> in_ready=1 combinationally; next cycle out_data=0x5.
6. Random push/pop/flush, 10k cycles, both SKID values, compared against a reference queue model -> order preserved, no loss outside flush, out_data=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with a valid/ready handshake and an optional second skid entry.
// Empty entries are kept all-zero so a drained or flushed stage presents a NOP payload downstream.
module pipe_stage_skid #(
    parameter int DATA_W = 160,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // the sender holds data and valid steady until then, and data is ignored when either is 0.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              push, pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // in_ready comes straight off a flop so out_ready never reaches the upstream stage.
            logic in_ready_q, in_ready_d;
            assign in_ready_d = (state_d != ST_FULL);
            assign in_ready   = in_ready_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) in_ready_q <= 1'b1;
                else     in_ready_q <= in_ready_d;
            end
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_d = in_data;
                end else if (push) begin
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
        // Flush wins over any same-cycle push; a same-cycle pop has already been taken downstream.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
